// File: rtl/mem_port_arbiter.sv
// Arbiter for one single-ported unified memory shared by the instruction-fetch
// port and the data port. Accesses are serialised through IDLE -> ISSUE ->
// (WAIT) -> RESP; every output is registered.
// Optional feature: define MEM_ARB_RR_EN for round-robin on simultaneous
// requests; otherwise the data port always wins a tie.
module mem_port_arbiter #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    // Instruction-fetch port
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_ready_o,
    output logic [DW-1:0] if_rdata_o,
    // Data port
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic          dm_ready_o,
    output logic [DW-1:0] dm_rdata_o,
    // Memory side
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    // Status
    output logic [1:0]    grant_o,
    output logic          busy_o
);

    // The latency counter is 4 bits wide, so only 1..15 can be represented.
    if (LAT < 1 || LAT > 15) begin : g_lat_check
        $error("mem_port_arbiter: LAT must be in the range 1..15");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          sel_dm_q, sel_dm_d;
    logic          if_ready_q, if_ready_d;
    logic          dm_ready_q, dm_ready_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]    grant_q, grant_d;
    logic          busy_q, busy_d;
    logic          dm_win;

`ifdef MEM_ARB_RR_EN
    // 1 = data port was granted last; cleared so the first tie goes to dm.
    logic          last_dm_q, last_dm_d;
`endif

    // Winner selection for a request sampled in IDLE.
    always_comb begin
        dm_win = 1'b0;
`ifdef MEM_ARB_RR_EN
        dm_win = dm_req_i && !(if_req_i && last_dm_q);
`else
        dm_win = dm_req_i;
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_dm_d    = sel_dm_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
`ifdef MEM_ARB_RR_EN
        last_dm_d   = last_dm_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (if_req_i || dm_req_i) begin
                    sel_dm_d    = dm_win;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_win && dm_we_i;
                    mem_addr_d  = dm_win ? dm_addr_i : if_addr_i;
                    mem_wdata_d = dm_win ? dm_wdata_i : '0;
                    grant_d     = dm_win ? 2'b10 : 2'b01;
                    busy_d      = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                // mem_we_q still holds the latched direction of this access.
                if (mem_we_q) begin
                    dm_ready_d = 1'b1;
                    state_d    = StResp;
                end else begin
                    cnt_d   = 4'(LAT);
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (sel_dm_q) begin
                        dm_rdata_d = mem_rdata_i;
                        dm_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata_i;
                        if_ready_d = 1'b1;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = StIdle;
`ifdef MEM_ARB_RR_EN
                last_dm_d = sel_dm_q;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sel_dm_q    <= 1'b0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_dm_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_dm_q    <= sel_dm_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
            last_dm_q   <= last_dm_d;
`endif
        end
    end

    assign if_ready_o  = if_ready_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_ready_o  = dm_ready_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a transaction-level schedule model. A second instance with
// LAT=4 covers long-latency reads and reset during an outstanding read.
module tb_mem_port_arbiter;

    localparam int LAT  = 1;
    localparam int LAT4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus
    logic        reset, reset4;
    logic        if_req, dm_req, if_req4, dm_req4;
    logic        dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;

    // Outputs of the LAT=1 instance
    logic        if_ready, dm_ready, mem_en, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant;
    // Outputs of the LAT=4 instance
    logic        if_ready_4, dm_ready_4, mem_en_4, mem_we_4, busy_4;
    logic [31:0] if_rdata_4, dm_rdata_4, mem_addr_4, mem_wdata_4, mem_rdata_4;
    logic [1:0]  grant_4;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT)) u_dut (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_ready_o(dm_ready), .dm_rdata_o(dm_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .grant_o(grant), .busy_o(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT4)) u_lat4 (
        .clk_i(clk), .reset_i(reset4),
        .if_req_i(if_req4), .if_addr_i(if_addr), .if_ready_o(if_ready_4),
        .if_rdata_o(if_rdata_4),
        .dm_req_i(dm_req4), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_ready_o(dm_ready_4), .dm_rdata_o(dm_rdata_4),
        .mem_en_o(mem_en_4), .mem_we_o(mem_we_4), .mem_addr_o(mem_addr_4),
        .mem_wdata_o(mem_wdata_4), .mem_rdata_i(mem_rdata_4), .grant_o(grant_4), .busy_o(busy_4)
    );

    // ---------------- Memory environment ----------------
    function automatic logic [31:0] init_val(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h2002_0005;
            32'h80:  return 32'hDEAD_BEEF;
            32'h100: return 32'hCAFE_F00D;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    bit   [31:0] mem_data [256];
    bit          mem_vld  [256];
    logic [31:0] pipe1 [LAT];
    logic [31:0] pipe4 [LAT4];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_vld[a[9:2]] ? mem_data[a[9:2]] : init_val(a);
    endfunction

    // Memory: writes on a strobed store, read data appears LAT cycles after
    // the strobe; other cycles carry random garbage.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_data[mem_addr[9:2]] <= mem_wdata;
            mem_vld[mem_addr[9:2]]  <= 1'b1;
        end
        if (mem_en_4 && mem_we_4) begin
            mem_data[mem_addr_4[9:2]] <= mem_wdata_4;
            mem_vld[mem_addr_4[9:2]]  <= 1'b1;
        end
        pipe1[0] <= (mem_en && !mem_we) ? mem_word(mem_addr) : $urandom();
        for (int k = 1; k < LAT; k++) pipe1[k] <= pipe1[k-1];
        pipe4[0] <= (mem_en_4 && !mem_we_4) ? mem_word(mem_addr_4) : $urandom();
        for (int k = 1; k < LAT4; k++) pipe4[k] <= pipe4[k-1];
    end
    assign mem_rdata   = pipe1[LAT-1];
    assign mem_rdata_4 = pipe4[LAT4-1];

    // ---------------- Reference model ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc, free_at, m_s, m_d, t_if, t_dm;
    bit          m_act, m_dm, m_we, ev_if, ev_dm;
    logic [31:0] m_addr, m_wdata, m_rdata, exp_if_rdata, exp_dm_rdata;
    logic [31:0] ref_mem [logic [31:0]];
`ifdef MEM_ARB_RR_EN
    bit          last_dm;
`endif

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        return a;
    endfunction

    // Arbitrate on the inputs of the current cycle, advance one clock, then
    // compare every output with the schedule.
    task automatic step();
        bit dm_w;
        bit win;
        if (!m_act && cyc >= free_at && (if_req || dm_req)) begin
            if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
                dm_w = !last_dm;
`else
                dm_w = 1'b1;
`endif
            end else begin
                dm_w = dm_req;
            end
            m_act   = 1'b1;
            m_s     = cyc;
            m_dm    = dm_w;
            m_we    = dm_w && dm_we;
            m_addr  = dm_w ? dm_addr : if_addr;
            m_wdata = dm_wdata;
            m_d     = cyc + (m_we ? 2 : 2 + LAT);
            if (m_we) ref_mem[m_addr] = m_wdata;
            else      m_rdata = ref_rd(m_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
        ev_if = m_act && cyc == m_d && !m_dm;
        ev_dm = m_act && cyc == m_d && m_dm;
        win   = m_act && cyc > m_s && cyc <= m_d;
        chk("grant", grant, win ? (m_dm ? 2'b10 : 2'b01) : 2'b00);
        chk("busy", busy, win);
        chk("mem_en", mem_en, m_act && cyc == m_s + 1);
        if (m_act && cyc == m_s + 1) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_ready", if_ready, ev_if);
        chk("dm_ready", dm_ready, ev_dm);
        if (ev_if) exp_if_rdata = m_rdata;
        if (ev_dm && !m_we) exp_dm_rdata = m_rdata;
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("dm_rdata", dm_rdata, exp_dm_rdata);
        if (m_act && cyc == m_d) begin
            m_act   = 1'b0;
            free_at = cyc + 1;
`ifdef MEM_ARB_RR_EN
            last_dm = m_dm;
`endif
        end
    endtask

    // Requesters drop on ready until both are quiet, then one idle cycle.
    task automatic serve();
        int budget = 200;
        while ((if_req || dm_req || m_act) && budget > 0) begin
            step();
            if (ev_if) begin if_req = 1'b0; t_if = cyc; end
            if (ev_dm) begin dm_req = 1'b0; t_dm = cyc; end
            budget--;
        end
        chk("serve_timeout", budget == 0, 1'b0);
        step();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        if_req = 1'b0;
        dm_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_if_ready", if_ready, 0);
        chk("rst_dm_ready", dm_ready, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        reset        = 1'b0;
        cyc          = 0;
        free_at      = 0;
        m_act        = 1'b0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
`ifdef MEM_ARB_RR_EN
        last_dm      = 1'b0;
`endif
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        int s0;
        int ncomp;
        int budget;
        bit seq [8];

        reset = 1'b1; reset4 = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; if_req4 = 1'b0; dm_req4 = 1'b0;
        dm_we = 1'b0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
        cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        reset4 = 1'b0;
        do_reset();

        // Single fetch
        if_req = 1'b1; if_addr = 32'h40;
        serve();
        chk("fetch_ready_cycle", t_if, 3);
        chk("fetch_data", if_rdata, 32'h2002_0005);

        // Store: two-cycle latency, load data register untouched
        s0 = cyc;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h54; dm_wdata = 32'h7;
        serve();
        chk("store_latency", t_dm - s0, 2);
        chk("store_keeps_dm_rdata", dm_rdata, 32'h0);
        dm_we = 1'b0;

        // Simultaneous fetch and load after reset: dm first, fetch follows
        do_reset();
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        serve();
        chk("tie_dm_ready_cycle", t_dm, 3);
        chk("tie_if_ready_cycle", t_if, 7);
        chk("tie_dm_data", dm_rdata, 32'hDEAD_BEEF);

        // Both ports re-requesting continuously for eight accesses
        do_reset();
        if_req = 1'b1; if_addr = rnd_addr();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = rnd_addr();
        ncomp  = 0;
        budget = 100;
        while (ncomp < 8 && budget > 0) begin
            step();
            if (ev_if) begin seq[ncomp] = 1'b0; ncomp++; if_addr = rnd_addr(); end
            if (ev_dm) begin seq[ncomp] = 1'b1; ncomp++; dm_addr = rnd_addr(); end
            budget--;
        end
        chk("contend_timeout", budget == 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_RR_EN
            chk($sformatf("contend_grant_%0d", i), seq[i], (i % 2) == 0);
`else
            chk($sformatf("contend_grant_%0d", i), seq[i], 1'b1);
`endif
        end
        serve();

        // Randomized traffic from both requesters
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = rnd_addr();
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = rnd_addr(); dm_wdata = $urandom();
            end
            step();
            if (ev_if) if_req = 1'b0;
            if (ev_dm) dm_req = 1'b0;
        end
        serve();
        dm_we = 1'b0;

        // LAT=4 instance: load from 0x100
        reset4 = 1'b1;
        @(posedge clk);
        #1;
        reset4 = 1'b0;
        chk("l4_rst_busy", busy_4, 0);
        chk("l4_rst_grant", grant_4, 0);
        dm_we = 1'b0; dm_addr = 32'h100; dm_req4 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("l4_mem_en_c%0d", c), mem_en_4, c == 1);
            if (c == 1) chk("l4_mem_addr", mem_addr_4, 32'h100);
            chk($sformatf("l4_busy_c%0d", c), busy_4, c <= 6);
            chk($sformatf("l4_grant_c%0d", c), grant_4, (c <= 6) ? 2'b10 : 2'b00);
            chk($sformatf("l4_dm_ready_c%0d", c), dm_ready_4, c == 6);
            chk($sformatf("l4_dm_rdata_c%0d", c), dm_rdata_4,
                (c >= 6) ? 32'hCAFE_F00D : 32'h0);
            chk($sformatf("l4_if_ready_c%0d", c), if_ready_4, 1'b0);
            if (c == 6) dm_req4 = 1'b0;
        end

        // LAT=4 instance: reset while waiting for read data
        dm_addr = 32'h104; dm_req4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("l4w_in_wait_busy", busy_4, 1'b1);
        reset4 = 1'b1; dm_req4 = 1'b0;
        @(posedge clk);
        #1;
        reset4 = 1'b0;
        chk("l4w_rst_if_ready", if_ready_4, 0);
        chk("l4w_rst_dm_ready", dm_ready_4, 0);
        chk("l4w_rst_if_rdata", if_rdata_4, 0);
        chk("l4w_rst_dm_rdata", dm_rdata_4, 0);
        chk("l4w_rst_mem_en", mem_en_4, 0);
        chk("l4w_rst_mem_we", mem_we_4, 0);
        chk("l4w_rst_mem_addr", mem_addr_4, 0);
        chk("l4w_rst_mem_wdata", mem_wdata_4, 0);
        chk("l4w_rst_grant", grant_4, 0);
        chk("l4w_rst_busy", busy_4, 0);
        for (int c = 4; c <= 9; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("l4w_no_ready_c%0d", c), dm_ready_4, 1'b0);
            chk($sformatf("l4w_rdata_kept_c%0d", c), dm_rdata_4, 32'h0);
            chk($sformatf("l4w_idle_busy_c%0d", c), busy_4, 1'b0);
            chk($sformatf("l4w_idle_en_c%0d", c), mem_en_4, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported unified memory between the pipeline's instruction-fetch port (read-only) and its data port (lw/lh/sw).
- Sits between the pipeline core and the shared memory and serialises accesses.
- Pipeline stall generation is derived from the per-port ready pulses.
- Fixed data-port priority by default; optional round-robin fairness.

Parameters:
AW, 32, address width in bits (byte address, passed through unmodified)
DW, 32, data width in bits
LAT, 1, memory read latency in cycles (legal 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr until if_ready
if_addr  in  AW  fetch address
if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DW  fetched instruction, held until next fetch completion
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ready
dm_we  in  1  1 = store, 0 = load
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_ready  out  1  one-cycle pulse: data access complete
dm_rdata  out  DW  load data, updated only on load completion
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid LAT cycles after the mem_en cycle
grant  out  2  one-hot owner {dm,if}; 00 when idle
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset: state=IDLE. All outputs 0: if_ready, dm_ready, if_rdata, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, grant, busy. The priority pointer clears to favour dm.
- Reset mid-access aborts the access with no ready pulse. Any mem_rdata still in flight is ignored.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests are sampled here only.
  - No request: stay in IDLE.
  - Otherwise select the winner, latch its addr/we/wdata, set grant, go to ISSUE.
  - Both requests: dm wins (fixed priority).
- ISSUE: mem_en=1 for exactly one cycle. mem_we=latched we (always 0 for if).
  - Store: go to RESP.
  - Read: load the latency counter with LAT, go to WAIT.
- WAIT: counter decrements each cycle. On the cycle mem_rdata is valid (counter reaches 1), capture mem_rdata into the winner's rdata register and go to RESP.
- RESP: the winner's ready=1 for exactly one cycle; the next state is IDLE. grant stays valid through RESP and clears in IDLE.
- Requester rules:
  - A requester that sees ready deasserts req on the following cycle, or presents a new request.
  - A req still high in IDLE is treated as a new access.
  - req must not drop before ready; behaviour if it does is undefined and flagged by the bench.
- Latency from req rising in IDLE at cycle 0:
  - Load/fetch: ready at cycle 2+LAT (LAT=1: cycle 3).
  - Store: ready at cycle 2.
  - Back-to-back accesses are spaced by one IDLE cycle minimum.
- The losing requester waits. Its req, addr and data must remain stable. There is no queuing inside the block.
- if_rdata/dm_rdata hold their values across other accesses. A store does not modify dm_rdata.
- Address and data pass through unaltered, with no alignment check. Sign extension for lh is done in the core.
- Counter: 4 bits wide. LAT outside 1..15 is a parameter error and must be caught by an elaboration-time check.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. A one-bit last-grant pointer updates in RESP.
  - When both requests are pending in IDLE, the port not granted last wins.
  - A single pending request wins regardless of the pointer.
  - The pointer resets to "last = if", so dm wins the first tie.
- Undefined: strict dm priority. A continuously asserted dm_req can starve if_req indefinitely; this is accepted because the pipeline stalls fetch during data accesses.

Test Plan:
- Single fetch, LAT=1: if_req=1, if_addr=0x0000_0040 at cycle 0, mem returns 0x2002_0005 → mem_en=1, mem_addr=0x40 at cycle 1; if_ready pulse at cycle 3; if_rdata=0x2002_0005; grant=01 in cycles 1–3.
- Store: dm_req=1, dm_we=1, dm_addr=0x54, dm_wdata=0x0000_0007 → cycle 1 mem_en=1, mem_we=1, mem_addr=0x54, mem_wdata=7; dm_ready at cycle 2; dm_rdata unchanged.
- Simultaneous if_req and dm load (addr 0x80, data 0xDEAD_BEEF), LAT=1, no macro → dm served first (dm_ready cycle 3). Fetch is issued at cycle 5 and if_ready arrives at cycle 7.
- With MEM_ARB_RR_EN, both requesters continuously re-requesting for 8 accesses → grants alternate dm, if, dm, if…. Without the macro all 8 grants go to dm.
- LAT=4 load from 0x100 → mem_en at cycle 1, mem_rdata sampled at cycle 5, dm_ready at cycle 6; busy=1 in cycles 1–6.
- Reset asserted during WAIT → next cycle: all outputs 0, state IDLE, no ready pulse. A later response on mem_rdata does not alter dm_rdata.
